// File: rtl/neuron_pkg.sv
// Shared types and constants for the rate-coded input stage of the synapse.
package neuron_pkg;

   localparam int          DATA_W_DEF         = 8;
   localparam int          SPIKING_WINDOW_DEF = 16;
   localparam logic [15:0] LFSR_TAPS          = 16'hB400;

   typedef logic [DATA_W_DEF-1:0] intensity_t;

   typedef enum logic {
      IDLE,
      ENCODE
   } enc_state_e;

endpackage

// File: rtl/spike_rate_encoder_lfsr.sv
// 16-bit right-shifting Galois LFSR; steps once per cycle with advance high, else holds.
// Latency: new value one cycle after advance; no backpressure (advance is the only control).
module lfsr16_galois
   import neuron_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        advance,
   input  logic [15:0] seed,
   output logic [15:0] value
);

   logic [15:0] value_q;
   logic [15:0] value_d;

   always_comb begin
      value_d = value_q;
      if (advance) begin
         value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= seed;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes one accepted intensity into SPIKING_WINDOW registered spike slots; accept at E gives slots after E+1..E+N.
// Backpressure: in_ready only in IDLE or on the last slot (abutting windows); enable=0 freezes everything and drops in_ready.
module spike_rate_encoder
   import neuron_pkg::*;
#(
   parameter int          SPIKING_WINDOW = SPIKING_WINDOW_DEF,
   parameter int          DATA_W         = DATA_W_DEF,
   parameter int          STOCHASTIC     = 0,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_intensity,
   output logic              pre_spike,
   output logic              window_start,
   output logic              window_done,
   output logic              busy
);

   localparam int               CNT_W     = (SPIKING_WINDOW > 1) ? $clog2(SPIKING_WINDOW) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SPIKING_WINDOW - 1);
   localparam logic [15:0]      SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   enc_state_e        state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] intensity_q, intensity_d;
   logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
   logic              pre_spike_q, pre_spike_d;
   logic              window_start_q, window_start_d;
   logic              window_done_q, window_done_d;

   logic [DATA_W:0]   sum;
   logic [15:0]       lfsr_value;
   logic              last_slot;
   logic              accept;
   logic              det_spike;
   logic              sto_spike;
   logic              slot_spike;
   logic              unused_lfsr_hi;

   lfsr16_galois u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (enable),
      .seed    (SEED_EFF),
      .value   (lfsr_value)
   );

   assign unused_lfsr_hi = ^lfsr_value[15:DATA_W];

   assign last_slot  = (state_q == ENCODE) && (slot_cnt_q == LAST_SLOT);
   assign in_ready   = enable && ((state_q == IDLE) || last_slot);
   assign accept     = in_valid && in_ready;

   // Carry out of the phase accumulator fires floor(N*I/2^DATA_W) times per window.
   assign sum        = {1'b0, acc_q} + {1'b0, intensity_q};
   assign det_spike  = sum[DATA_W];
   assign sto_spike  = (lfsr_value[DATA_W-1:0] < intensity_q);
   assign slot_spike = (STOCHASTIC != 0) ? sto_spike : det_spike;

   always_comb begin
      state_d        = state_q;
      acc_d          = acc_q;
      intensity_d    = intensity_q;
      slot_cnt_d     = slot_cnt_q;
      pre_spike_d    = 1'b0;
      window_start_d = 1'b0;
      window_done_d  = 1'b0;

      if (enable) begin
         if (state_q == ENCODE) begin
            pre_spike_d    = slot_spike;
            window_start_d = (slot_cnt_q == '0);
            window_done_d  = last_slot;
            acc_d          = sum[DATA_W-1:0];
            if (last_slot) begin
               state_d    = IDLE;
               slot_cnt_d = '0;
            end else begin
               slot_cnt_d = slot_cnt_q + 1'b1;
            end
         end
         // An accept on the last slot overrides the return to IDLE so windows abut.
         if (accept) begin
            state_d     = ENCODE;
            intensity_d = in_intensity;
            acc_d       = '0;
            slot_cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         acc_q          <= '0;
         intensity_q    <= '0;
         slot_cnt_q     <= '0;
         pre_spike_q    <= 1'b0;
         window_start_q <= 1'b0;
         window_done_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         acc_q          <= acc_d;
         intensity_q    <= intensity_d;
         slot_cnt_q     <= slot_cnt_d;
         pre_spike_q    <= pre_spike_d;
         window_start_q <= window_start_d;
         window_done_q  <= window_done_d;
      end
   end

   assign pre_spike    = pre_spike_q;
   assign window_start = window_start_q;
   assign window_done  = window_done_q;
   assign busy         = (state_q == ENCODE);

endmodule
